// File: rtl/sample_accumulator_pkg.sv
// Shared state codes and FSM type for the sample accumulator.
// The raw codes let status readback and test code agree on the encoding.
package sample_accumulator_pkg;

   localparam logic [1:0] STATE_IDLE = 2'd0;
   localparam logic [1:0] STATE_SYNC = 2'd1;
   localparam logic [1:0] STATE_RUN  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = STATE_IDLE,
      ST_SYNC = STATE_SYNC,
      ST_RUN  = STATE_RUN
   } acc_state_t;

endpackage

// File: rtl/sample_accumulator_sat_add.sv
// Combinational signed saturating adder: sum = clamp(a + sext(b)) at A_WI bits.
// Requires B_WI <= A_WI; clip flags that the result was clamped.
module sat_add #(
   parameter int A_WI = 32,
   parameter int B_WI = 16
) (
   input  logic signed [A_WI-1:0] a,
   input  logic signed [B_WI-1:0] b,
   output logic signed [A_WI-1:0] sum,
   output logic                   clip
);

   logic [A_WI:0] wide;

   // One guard bit is enough: disagreement with the MSB means the add overflowed.
   always_comb begin
      wide = {a[A_WI-1], a} + {{(A_WI - B_WI + 1){b[B_WI-1]}}, b};
      clip = wide[A_WI] != wide[A_WI-1];
      sum  = wide[A_WI-1:0];
      if (clip) begin
         sum = wide[A_WI] ? {1'b1, {(A_WI-1){1'b0}}} : {1'b0, {(A_WI-1){1'b1}}};
      end
   end

endmodule

// File: rtl/sample_accumulator.sv
// Boxcar decimator: sums signed samples between dump strobes and presents the
// shifted window sum and sample count through a 1-deep valid/ready register.
module sample_accumulator
   import sample_accumulator_pkg::*;
#(
   parameter int DATA_WI  = 16,
   parameter int ACC_WI   = 32,
   parameter int CNT_WI   = 16,
   parameter int SHIFT_WI = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      sample_stb,
   input  logic                      dump_stb,
   input  logic signed [DATA_WI-1:0] din,
   input  logic [SHIFT_WI-1:0]       shift,
   output logic signed [ACC_WI-1:0]  out_data,
   output logic [CNT_WI-1:0]         out_count,
   output logic                      out_valid,
   input  logic                      out_ready,
   input  logic                      clear_flags,
   output logic                      overrun,
   output logic                      saturated
);

   acc_state_t               state;
   acc_state_t               state_next;
   logic                     run_active;
   logic signed [ACC_WI-1:0] acc;
   logic [CNT_WI-1:0]        cnt;
   logic signed [ACC_WI-1:0] add_sum;
   logic                     add_clip;
   logic signed [ACC_WI-1:0] window_sum;
   logic [CNT_WI-1:0]        cnt_inc;
   logic [CNT_WI-1:0]        window_cnt;
   logic signed [ACC_WI-1:0] shifted;
   logic                     do_sample;
   logic                     do_dump;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Dropping enable wins over any strobe; the SYNC dump only aligns to the window grid.
   always_comb begin
      state_next = state;
      run_active = 1'b0;
      case (state)
         ST_IDLE: if (enable) state_next = ST_SYNC;
         ST_SYNC: begin
            if (!enable)       state_next = ST_IDLE;
            else if (dump_stb) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (!enable) state_next = ST_IDLE;
            else         run_active = 1'b1;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   sat_add #(
      .A_WI (ACC_WI),
      .B_WI (DATA_WI)
   ) u_sat_add (
      .a    (acc),
      .b    (din),
      .sum  (add_sum),
      .clip (add_clip)
   );

   assign do_sample  = run_active & sample_stb;
   assign do_dump    = run_active & dump_stb;
   assign cnt_inc    = (&cnt) ? cnt : cnt + CNT_WI'(1);
   assign window_sum = sample_stb ? add_sum : acc;
   assign window_cnt = sample_stb ? cnt_inc : cnt;

   // Shifts at or beyond the accumulator width collapse to pure sign fill.
   always_comb begin
      if (32'(shift) >= ACC_WI) shifted = {ACC_WI{window_sum[ACC_WI-1]}};
      else                      shifted = window_sum >>> shift;
   end

   // A sample coinciding with a dump closes the window being dumped.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         cnt       <= '0;
         out_data  <= '0;
         out_count <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         saturated <= 1'b0;
      end else begin
         if (!run_active || do_dump) begin
            acc <= '0;
            cnt <= '0;
         end else if (do_sample) begin
            acc <= add_sum;
            cnt <= cnt_inc;
         end

         if (do_dump) begin
            out_data  <= shifted;
            out_count <= window_cnt;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         overrun   <= (do_dump & out_valid & ~out_ready) | (overrun & ~clear_flags);
         saturated <= (do_sample & add_clip) | (saturated & ~clear_flags);
      end
   end

endmodule
